// File: rtl/product_acc_pkg.sv
// Shared widths and FSM encoding for the product accumulator.
package product_acc_pkg;

  localparam int PROD_W    = 64;
  localparam int ACC_W_DEF = 72;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic logic [ACC_W_DEF-1:0] sext_prod(
    input logic [PROD_W-1:0] p
  );
    return {{(ACC_W_DEF-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/acc_saturate.sv
// Narrows the wide accumulator to 64-bit signed and flags out-of-range.
// Saturates when PRODUCT_ACC_SAT_EN is defined, otherwise wraps.
module acc_saturate
  import product_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [PROD_W-1:0] res,
  output logic              oor
);

  // In range iff every bit from the 64-bit sign bit up matches.
  logic [ACC_W-PROD_W:0] upper;

  assign upper = acc[ACC_W-1:PROD_W-1];
  assign oor   = !((&upper) || !(|upper));

`ifdef PRODUCT_ACC_SAT_EN
  always_comb begin
    res = acc[PROD_W-1:0];
    if (oor) begin
      if (acc[ACC_W-1])
        res = {1'b1, {(PROD_W-1){1'b0}}};
      else
        res = {1'b0, {(PROD_W-1){1'b1}}};
    end
  end
`else
  assign res = acc[PROD_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums TERMS signed 64-bit products and holds the result for handoff.
// Build option: PRODUCT_ACC_SAT_EN saturates acc_out instead of wrapping.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter  int TERMS = 4,
  parameter  int ACC_W = ACC_W_DEF,
  localparam int CNT_W = $clog2(TERMS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic              clear,
  output logic [PROD_W-1:0] acc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  count
);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               valid;
  logic [PROD_W-1:0]  narrow;
  logic               oor;
  logic [ACC_W-1:0]   prod_ext;
  logic               last;

  assign prod_ext   = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign last       = (cnt == CNT_W'(TERMS - 1));
  assign prod_ready = (state == ACCUM) && en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (en) begin
      case (state)
        ACCUM: begin
          if (prod_valid) begin
            acc <= acc + prod_ext;
            cnt <= cnt + 1'b1;
            if (last) begin
              state <= HOLD;
              valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  acc_saturate #(
    .ACC_W (ACC_W)
  ) u_sat (
    .acc (acc),
    .res (narrow),
    .oor (oor)
  );

  // Result and flag are only meaningful while a sum is held.
  assign acc_out   = valid ? narrow : '0;
  assign overflow  = valid & oor;
  assign out_valid = valid;
  assign count     = cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed plus randomized bench for product_accumulator (TERMS=4).
// Reference model: queue of accepted products summed with wide arithmetic.
module tb_product_accumulator;

  localparam int TERMS = 4;
  localparam int CW    = $clog2(TERMS + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [63:0]   prod;
  logic          prod_valid;
  logic          prod_ready;
  logic          clear;
  logic [63:0]   acc_out;
  logic          out_valid;
  logic          out_ready;
  logic          overflow;
  logic [CW-1:0] count;

  int passed = 0;
  int total  = 0;

  longint q[$];

  product_accumulator #(.TERMS(TERMS), .ACC_W(72)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .clear      (clear),
    .acc_out    (acc_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic signed [71:0] model_sum();
    logic signed [71:0] s = '0;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  function automatic bit model_oor();
    logic signed [71:0] s = model_sum();
    logic signed [71:0] maxv = 72'sh7FFF_FFFF_FFFF_FFFF;
    logic signed [71:0] minv = -maxv - 72'sd1;
    return (s > maxv) || (s < minv);
  endfunction

  function automatic logic [63:0] model_out();
    logic signed [71:0] s = model_sum();
    if (q.size() != TERMS) return '0;
`ifdef PRODUCT_ACC_SAT_EN
    if (model_oor())
      return s[71] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return s[63:0];
  endfunction

  task automatic check_all(input string tag);
    bit held = (q.size() == TERMS);
    check({tag, ".ready"}, 64'(prod_ready), 64'(!held && en));
    check({tag, ".valid"}, 64'(out_valid), 64'(held));
    check({tag, ".count"}, 64'(count), 64'(q.size()));
    check({tag, ".acc"}, acc_out, model_out());
    check({tag, ".ovf"}, 64'(overflow), 64'(held && model_oor()));
  endtask

  // Advance one edge, applying the spec's rules to the model first.
  task automatic tick(input string tag);
    bit held = (q.size() == TERMS);
    if (clear) q.delete();
    else if (en) begin
      if (!held && prod_valid) q.push_back(longint'(prod));
      else if (held && out_ready) q.delete();
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [63:0] p,
                       input logic r, input logic e, input logic c);
    prod_valid = v;
    prod       = p;
    out_ready  = r;
    en         = e;
    clear      = c;
  endtask

  logic [63:0] held_val;
  logic [63:0] rp;
  int          seq1[4] = '{464960160, -143362716, 67081, 0};

  initial begin
    reset = 1'b1;
    drive(0, '0, 0, 1, 0);
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_reset");

    // Reset mid-sum after two accepts
    drive(1, 64'd11, 0, 1, 0);
    tick("mid1");
    drive(1, 64'd22, 0, 1, 0);
    tick("mid2");
    check("mid.count2", 64'(count), 64'd2);
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    check_all("async_reset");
    check("async_reset.count", 64'(count), 64'd0);
    drive(0, '0, 0, 1, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("release.ready", 64'(prod_ready), 64'd1);
    check_all("release");

    // Known sum, one-cycle result latency
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'(longint'(seq1[i])), 0, 1, 0);
      tick("seq1");
    end
    check("seq1.valid", 64'(out_valid), 64'd1);
    check("seq1.acc", acc_out, 64'd321664525);
    check("seq1.ovf", 64'(overflow), 64'd0);
    drive(0, '0, 1, 1, 0);
    tick("seq1.pop");

    // Positive overflow
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0);
      tick("ovf");
    end
    check("ovf.flag", 64'(overflow), 64'd1);
`ifdef PRODUCT_ACC_SAT_EN
    check("ovf.acc", acc_out, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    check("ovf.acc", acc_out, 64'hFFFF_FFFF_FFFF_FFFC);
`endif

    // Backpressure in HOLD with products still offered
    held_val = acc_out;
    for (int i = 0; i < 5; i++) begin
      drive(1, 64'd99, 0, 1, 0);
      tick("hold");
      check("hold.stable", acc_out, held_val);
      check("hold.ready", 64'(prod_ready), 64'd0);
    end
    drive(0, '0, 1, 1, 0);
    tick("hold.pop");
    check("hold.pop.valid", 64'(out_valid), 64'd0);
    check("hold.pop.ready", 64'(prod_ready), 64'd1);

    // Clear beats a simultaneous accept
    drive(1, 64'd5, 0, 1, 0);
    tick("clr5");
    drive(1, 64'd7, 0, 1, 0);
    tick("clr7");
    drive(1, 64'd3, 0, 1, 1);
    tick("clr");
    check("clr.count", 64'(count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 64'd1, 0, 1, 0);
      tick("ones");
    end
    check("ones.acc", acc_out, 64'd4);
    drive(0, '0, 1, 1, 0);
    tick("ones.pop");

    // Enable low freezes a partial sum
    drive(1, -64'sd9, 0, 1, 0);
    tick("en.a");
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'd1000, 1, 0, 0);
      #1;
      check("en.ready", 64'(prod_ready), 64'd0);
      tick("en.off");
      check("en.count", 64'(count), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'(i + 2), 0, 1, 0);
      tick("en.on");
    end
    check("en.acc", acc_out, 64'(-64'sd9 + 64'sd9));
    drive(0, '0, 1, 1, 0);
    tick("en.pop");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: rp = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
        1: rp = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 3));
        default: rp = {$urandom, $urandom};
      endcase
      drive($urandom_range(0, 3) != 0, rp, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) != 0, $urandom_range(0, 40) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
